// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the three-port SRAM arbiter.
//   - arb_state_e     : arbiter FSM encodings (A_IDLE / A_GRANT)
//   - MEM_ARB_PORTS   : number of masters (3)
//   - ID/ADDR/DATA/MASK widths of the memory port
//   - onehot_to_idx() : converts a one-hot winner into a master index
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_PORTS = 3;
  localparam int unsigned ID_WIDTH      = 2;
  localparam int unsigned ADDR_WIDTH    = 30;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned MASK_WIDTH    = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    A_IDLE  = 1'b0,
    A_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [ID_WIDTH-1:0] onehot_to_idx(input logic [MEM_ARB_PORTS-1:0] oh);
    logic [ID_WIDTH-1:0] idx;
    idx = '0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection for mem_arbiter.
// Macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin search starting at 'pointer';
//        undefined gives fixed priority master 0 > 1 > 2 and ignores 'pointer'.
// Ports:
//   eligible  in  3  masters that may be granted this cycle
//   pointer   in  2  first master to consider (round-robin only)
//   winner    out 3  one-hot chosen master, zero when nothing is eligible
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [MEM_ARB_PORTS-1:0] eligible,
  input  logic [1:0]               pointer,
  output logic [MEM_ARB_PORTS-1:0] winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = '0;
    case (pointer)
      2'd1: begin
        if      (eligible[1]) winner = 3'b010;
        else if (eligible[2]) winner = 3'b100;
        else if (eligible[0]) winner = 3'b001;
      end
      2'd2: begin
        if      (eligible[2]) winner = 3'b100;
        else if (eligible[0]) winner = 3'b001;
        else if (eligible[1]) winner = 3'b010;
      end
      default: begin
        if      (eligible[0]) winner = 3'b001;
        else if (eligible[1]) winner = 3'b010;
        else if (eligible[2]) winner = 3'b100;
      end
    endcase
  end
`else
  logic unused_pointer;
  assign unused_pointer = ^pointer;

  always_comb begin
    winner = '0;
    if      (eligible[0]) winner = 3'b001;
    else if (eligible[1]) winner = 3'b010;
    else if (eligible[2]) winner = 3'b100;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one id-tagged, burst-read SRAM port between three masters.
// Macro: MEM_ARB_ROUND_ROBIN_EN enables round-robin priority (default: fixed 0 > 1 > 2).
// Ports:
//   clock, rst_n                      clock and asynchronous active-low reset
//   port_waitrequest    out 3         low for the granted master in its accept cycle
//   port_address        in  3x30      per-master word address
//   port_read/write     in  3 each    per-master command strobes, held until accepted
//   port_writedata      in  3x32      per-master write data
//   port_writedatamask  in  3x4       per-master byte mask
//   port_readdata       out 32        broadcast of mem_readdata
//   port_readdatavalid  out 3         beat for master i (mem_readdataid == i+1)
//   mem_waitrequest     in  1         downstream stall
//   mem_id/address/read/write/writedata/writedatamask  out  registered command
//   mem_readdata        in  32        returned beat data
//   mem_readdataid      in  2         0 = no beat, 1..3 = beat owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned burst_bits = 2
) (
  input  logic                                clock,
  input  logic                                rst_n,
  output logic [MEM_ARB_PORTS-1:0]            port_waitrequest,
  input  logic [MEM_ARB_PORTS*ADDR_WIDTH-1:0] port_address,
  input  logic [MEM_ARB_PORTS-1:0]            port_read,
  input  logic [MEM_ARB_PORTS-1:0]            port_write,
  input  logic [MEM_ARB_PORTS*DATA_WIDTH-1:0] port_writedata,
  input  logic [MEM_ARB_PORTS*MASK_WIDTH-1:0] port_writedatamask,
  output logic [DATA_WIDTH-1:0]               port_readdata,
  output logic [MEM_ARB_PORTS-1:0]            port_readdatavalid,
  input  logic                                mem_waitrequest,
  output logic [ID_WIDTH-1:0]                 mem_id,
  output logic [ADDR_WIDTH-1:0]               mem_address,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [DATA_WIDTH-1:0]               mem_writedata,
  output logic [MASK_WIDTH-1:0]               mem_writedatamask,
  input  logic [DATA_WIDTH-1:0]               mem_readdata,
  input  logic [ID_WIDTH-1:0]                 mem_readdataid
);

  localparam int unsigned beat_width   = burst_bits + 1;
  localparam int unsigned burst_length = 1 << burst_bits;
  localparam logic [beat_width-1:0] BurstLoad = beat_width'(burst_length);

  arb_state_e                state_q;
  logic [ID_WIDTH-1:0]       grant_q;
  logic [MEM_ARB_PORTS-1:0]  pending_q;
  logic [beat_width-1:0]     beats_q [MEM_ARB_PORTS];
  logic                      stray_beat_q;
  logic [1:0]                rr_ptr;

  logic [MEM_ARB_PORTS-1:0]  eligible;
  logic [MEM_ARB_PORTS-1:0]  winner;
  logic [ID_WIDTH-1:0]       winner_idx;
  logic                      accept;
  logic                      stray_hit;

  assign eligible   = (port_read | port_write) & ~pending_q;
  assign winner_idx = onehot_to_idx(winner);
  assign accept     = (state_q == A_GRANT) && !mem_waitrequest;

  mem_arb_pick u_pick (
    .eligible (eligible),
    .pointer  (rr_ptr),
    .winner   (winner)
  );

  // Return path is purely combinational: zero-latency steering by id.
  assign port_readdata = mem_readdata;

  always_comb begin
    port_readdatavalid = '0;
    for (int i = 0; i < MEM_ARB_PORTS; i++) begin
      port_readdatavalid[i] = (mem_readdataid == ID_WIDTH'(i + 1));
    end
  end

  always_comb begin
    port_waitrequest = '1;
    if (accept) port_waitrequest[grant_q] = 1'b0;
  end

  // A beat is stray when its owner has no burst outstanding.
  always_comb begin
    stray_hit = 1'b0;
    for (int i = 0; i < MEM_ARB_PORTS; i++) begin
      if (port_readdatavalid[i] && (!pending_q[i] || beats_q[i] == '0)) stray_hit = 1'b1;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (accept) begin
      rr_ptr <= (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
    end
  end
`else
  assign rr_ptr = 2'd0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= A_IDLE;
      grant_q           <= '0;
      pending_q         <= '0;
      for (int i = 0; i < MEM_ARB_PORTS; i++) beats_q[i] <= '0;
      stray_beat_q      <= 1'b0;
      mem_id            <= '0;
      mem_address       <= '0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      mem_writedata     <= '0;
      mem_writedatamask <= '0;
    end else begin
      stray_beat_q <= stray_beat_q | stray_hit;

      for (int i = 0; i < MEM_ARB_PORTS; i++) begin
        if (port_readdatavalid[i] && pending_q[i] && beats_q[i] != '0) begin
          beats_q[i] <= beats_q[i] - 1'b1;
          if (beats_q[i] == beat_width'(1)) pending_q[i] <= 1'b0;
        end
      end

      case (state_q)
        A_IDLE: begin
          if (|eligible) begin
            state_q           <= A_GRANT;
            grant_q           <= winner_idx;
            mem_id            <= winner_idx + 2'd1;
            mem_address       <= port_address[ADDR_WIDTH*winner_idx +: ADDR_WIDTH];
            mem_writedata     <= port_writedata[DATA_WIDTH*winner_idx +: DATA_WIDTH];
            mem_writedatamask <= port_writedatamask[MASK_WIDTH*winner_idx +: MASK_WIDTH];
            // Read wins when a master raises both strobes.
            mem_read          <= port_read[winner_idx];
            mem_write         <= port_write[winner_idx] & ~port_read[winner_idx];
          end
        end
        A_GRANT: begin
          if (!mem_waitrequest) begin
            state_q   <= A_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            // Granted master cannot have a beat in flight, so this load never races a decrement.
            if (mem_read) begin
              pending_q[grant_q] <= 1'b1;
              beats_q[grant_q]   <= BurstLoad;
            end
          end
        end
        default: state_q <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [2:0]  port_waitrequest;
  logic [89:0] port_address;
  logic [2:0]  port_read;
  logic [2:0]  port_write;
  logic [95:0] port_writedata;
  logic [11:0] port_writedatamask;
  logic [31:0] port_readdata;
  logic [2:0]  port_readdatavalid;
  logic        mem_waitrequest;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_readdataid;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.burst_bits(2)) dut (
    .clock              (clock),
    .rst_n              (rst_n),
    .port_waitrequest   (port_waitrequest),
    .port_address       (port_address),
    .port_read          (port_read),
    .port_write         (port_write),
    .port_writedata     (port_writedata),
    .port_writedatamask (port_writedatamask),
    .port_readdata      (port_readdata),
    .port_readdatavalid (port_readdatavalid),
    .mem_waitrequest    (mem_waitrequest),
    .mem_id             (mem_id),
    .mem_address        (mem_address),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_writedata      (mem_writedata),
    .mem_writedatamask  (mem_writedatamask),
    .mem_readdata       (mem_readdata),
    .mem_readdataid     (mem_readdataid)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    port_address       = '0;
    port_read          = '0;
    port_write         = '0;
    port_writedata     = '0;
    port_writedatamask = '0;
    mem_waitrequest    = 1'b0;
    mem_readdata       = '0;
    mem_readdataid     = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_m;
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    tick();
    check_eq("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check_eq("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check_eq("rst_mem_id", {30'd0, mem_id}, 32'd0);
    check_eq("rst_mem_address", {2'd0, mem_address}, 32'd0);
    check_eq("rst_port_wait", {29'd0, port_waitrequest}, 32'h7);
    #1 rst_n = 1'b1;

    // Single read by master 0
    tick();
    port_read[0] = 1'b1;
    port_address[29:0] = 30'h100;
    #1 check_eq("rd_wait_idle", {29'd0, port_waitrequest}, 32'h7);
    tick();
    check_eq("rd_mem_read", {31'd0, mem_read}, 32'd1);
    check_eq("rd_mem_id", {30'd0, mem_id}, 32'd1);
    check_eq("rd_mem_addr", {2'd0, mem_address}, 32'h100);
    check_eq("rd_port_wait", {29'd0, port_waitrequest}, 32'h6);
    port_read[0] = 1'b0;
    tick();
    check_eq("rd_read_clear", {31'd0, mem_read}, 32'd0);
    check_eq("rd_pending_set", {29'd0, dut.pending_q}, 32'h1);
    for (int b = 0; b < 4; b++) begin
      mem_readdataid = 2'd1;
      mem_readdata = 32'hA0 + b;
      #1;
      check_eq("rd_beat_valid", {29'd0, port_readdatavalid}, 32'h1);
      check_eq("rd_beat_data", port_readdata, 32'hA0 + b);
      tick();
    end
    mem_readdataid = 2'd0;
    #1;
    check_eq("rd_pending_clear", {29'd0, dut.pending_q}, 32'h0);
    check_eq("rd_no_stray", {31'd0, dut.stray_beat_q}, 32'd0);
    check_eq("rd_valid_idle", {29'd0, port_readdatavalid}, 32'h0);

    // Contention: all three masters write continuously
    pulse_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      port_address[30*i +: 30] = 30'h1000 + 30'(i);
      port_writedata[32*i +: 32] = 32'h11111111 * (i + 1);
    end
    port_write = 3'b111;
    for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_m = g % 3;
`else
      exp_m = 0;
`endif
      tick();
      check_eq("cont_mem_id", {30'd0, mem_id}, 32'(exp_m + 1));
      check_eq("cont_mem_addr", {2'd0, mem_address}, 32'h1000 + 32'(exp_m));
      check_eq("cont_wdata", mem_writedata, 32'h11111111 * (exp_m + 1));
      check_eq("cont_port_wait", {29'd0, port_waitrequest}, 32'h7 & ~(32'd1 << exp_m));
      tick();
    end
    idle_inputs();

    // Pending block: master 1 holds a second read during its burst
    pulse_reset();
    tick();
    port_read = 3'b010;
    port_address[59:30] = 30'h300;
    #1;
    tick();
    check_eq("pb_m1_id", {30'd0, mem_id}, 32'd2);
    check_eq("pb_m1_read", {31'd0, mem_read}, 32'd1);
    check_eq("pb_m1_wait", {29'd0, port_waitrequest}, 32'h5);
    port_write[2] = 1'b1;
    port_address[89:60] = 30'h400;
    tick();
    check_eq("pb_pending", {29'd0, dut.pending_q}, 32'h2);
    check_eq("pb_wait_idle", {29'd0, port_waitrequest}, 32'h7);
    tick();
    check_eq("pb_m2_id", {30'd0, mem_id}, 32'd3);
    check_eq("pb_m2_write", {31'd0, mem_write}, 32'd1);
    check_eq("pb_m2_wait", {29'd0, port_waitrequest}, 32'h3);
    port_write[2] = 1'b0;
    mem_readdataid = 2'd2;
    mem_readdata = 32'hB0;
    #1 check_eq("pb_beat0", {29'd0, port_readdatavalid}, 32'h2);
    tick();
    for (int b = 1; b < 4; b++) begin
      mem_readdataid = 2'd2;
      mem_readdata = 32'hB0 + b;
      #1;
      check_eq("pb_beat_valid", {29'd0, port_readdatavalid}, 32'h2);
      check_eq("pb_blocked", {31'd0, mem_read}, 32'd0);
      tick();
    end
    mem_readdataid = 2'd0;
    #1;
    check_eq("pb_pending_clr", {29'd0, dut.pending_q}, 32'h0);
    check_eq("pb_not_yet", {31'd0, mem_read}, 32'd0);
    tick();
    check_eq("pb_regrant_id", {30'd0, mem_id}, 32'd2);
    check_eq("pb_regrant_rd", {31'd0, mem_read}, 32'd1);
    port_read = 3'b000;
    tick();
    for (int b = 0; b < 4; b++) begin
      mem_readdataid = 2'd2;
      #1;
      tick();
    end
    mem_readdataid = 2'd3;
    mem_readdata = 32'h5757;
    #1 check_eq("stray_valid", {29'd0, port_readdatavalid}, 32'h4);
    tick();
    mem_readdataid = 2'd0;
    #1;
    check_eq("stray_sticky", {31'd0, dut.stray_beat_q}, 32'd1);
    check_eq("stray_no_wrap", {29'd0, dut.beats_q[2]}, 32'd0);
    check_eq("stray_pending", {29'd0, dut.pending_q}, 32'h0);

    // Downstream stall on a master 2 write
    tick();
    mem_waitrequest = 1'b1;
    port_write[2] = 1'b1;
    port_address[89:60] = 30'h3ABCDEF;
    port_writedata[95:64] = 32'hDEADBEEF;
    port_writedatamask[11:8] = 4'h3;
    #1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("st_write", {31'd0, mem_write}, 32'd1);
      check_eq("st_wdata", mem_writedata, 32'hDEADBEEF);
      check_eq("st_mask", {28'd0, mem_writedatamask}, 32'h3);
      check_eq("st_addr", {2'd0, mem_address}, 32'h3ABCDEF);
      check_eq("st_id", {30'd0, mem_id}, 32'd3);
      check_eq("st_wait", {29'd0, port_waitrequest}, 32'h7);
      tick();
    end
    mem_waitrequest = 1'b0;
    #1;
    check_eq("st_release_wait", {29'd0, port_waitrequest}, 32'h3);
    check_eq("st_release_wr", {31'd0, mem_write}, 32'd1);
    idle_inputs();
    tick();
    check_eq("st_write_clear", {31'd0, mem_write}, 32'd0);

    // Reset mid-burst with a stalled write in flight
    tick();
    port_read = 3'b001;
    port_address[29:0] = 30'h200;
    #1;
    tick();
    check_eq("rm_read", {31'd0, mem_read}, 32'd1);
    port_read = 3'b000;
    tick();
    mem_waitrequest = 1'b1;
    port_write = 3'b010;
    port_address[59:30] = 30'h55;
    mem_readdataid = 2'd1;
    mem_readdata = 32'hC0;
    #1 check_eq("rm_beat1", {29'd0, port_readdatavalid}, 32'h1);
    tick();
    mem_readdata = 32'hC1;
    #1;
    check_eq("rm_wr_granted", {31'd0, mem_write}, 32'd1);
    check_eq("rm_wr_id", {30'd0, mem_id}, 32'd2);
    tick();
    mem_readdataid = 2'd0;
    port_write = 3'b000;
    #1 check_eq("rm_beats_mid", {29'd0, dut.beats_q[0]}, 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("rm_write", {31'd0, mem_write}, 32'd0);
    check_eq("rm_id", {30'd0, mem_id}, 32'd0);
    check_eq("rm_addr", {2'd0, mem_address}, 32'd0);
    check_eq("rm_pending", {29'd0, dut.pending_q}, 32'h0);
    check_eq("rm_beats", {29'd0, dut.beats_q[0]}, 32'd0);
    check_eq("rm_wait", {29'd0, port_waitrequest}, 32'h7);
    #1;
    rst_n = 1'b1;
    mem_waitrequest = 1'b0;
    mem_readdataid = 2'd1;
    #1 check_eq("rm_late_valid", {29'd0, port_readdatavalid}, 32'h1);
    tick();
    mem_readdataid = 2'd0;
    #1;
    check_eq("rm_late_stray", {31'd0, dut.stray_beat_q}, 32'd1);
    check_eq("rm_late_pending", {29'd0, dut.pending_q}, 32'h0);
    check_eq("rm_late_beats", {29'd0, dut.beats_q[0]}, 32'd0);
    port_read = 3'b001;
    port_address[29:0] = 30'h300;
    tick();
    check_eq("rm_new_read", {31'd0, mem_read}, 32'd1);
    check_eq("rm_new_id", {30'd0, mem_id}, 32'd1);
    check_eq("rm_new_addr", {2'd0, mem_address}, 32'h300);
    check_eq("rm_new_wait", {29'd0, port_waitrequest}, 32'h6);
    port_read = 3'b000;
    tick();
    check_eq("rm_new_clear", {31'd0, mem_read}, 32'd0);
    check_eq("rm_new_pending", {29'd0, dut.pending_q}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Three-port arbiter that shares the single SRAM memory port (`mem_*`, burst-read, id-tagged) between up to three masters, e.g. I-fetch, D-cache and DMA. It picks one pending command per arbitration and forwards it downstream with that master's id (1..3). It steers id-tagged read beats back to their originator and tracks each master's outstanding read burst. It sits between the masters and the SRAM controller.

## Interface
- `burst_bits`, 2: log2 of read burst length; must match the SRAM controller.
- `burst_length`, `1 << burst_bits`: beats returned per read command.
- `clock`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `port_waitrequest`  out  3  per-master stall; bit i low = master i's command accepted this cycle.
- `port_address`  in  90  3×30-bit word addresses; master i at [30i+29:30i].
- `port_read`, `port_write`  in  3 each  per-master command strobes; held until accepted.
- `port_writedata`  in  96  3×32.
- `port_writedatamask`  in  12  3×4.
- `port_readdata`  out  32  broadcast of `mem_readdata`.
- `port_readdatavalid`  out  3  bit i high = beat for master i this cycle.
- `mem_waitrequest`  in  1  downstream stall.
- `mem_id`  out  2  granted master + 1.
- `mem_address`  out  30.
- `mem_read`, `mem_write`  out  1 each.
- `mem_writedata`  out  32.
- `mem_writedatamask`  out  4.
- `mem_readdata`  in  32.
- `mem_readdataid`  in  2  0 = no beat; 1..3 = beat for that id.

## Operation
- States: `A_IDLE`, `A_GRANT`.
- **Eligibility:** master i is eligible when `port_read[i] | port_write[i]` and `pending[i]` (registered) is 0.
- **A_IDLE:** if any master is eligible, choose one by priority order. Register `grant`, `mem_id`, address, data, mask and read/write into the `mem_*` outputs. Go to `A_GRANT`. If read and write are both asserted by one master, read wins.
- **A_GRANT:** hold `mem_*` stable.
- **Acceptance:** when `mem_waitrequest` is 0, the command is accepted.
  - `port_waitrequest[grant]` is 0 combinationally in that same cycle.
  - `mem_read`/`mem_write` clear at the next edge.
  - The FSM returns to `A_IDLE`.
- **Waitrequest rule:** `port_waitrequest` is 1 for every master in every other case.
- **Read acceptance:** on an accepted read, `pending[grant]` is set and `beats[grant]` is loaded with `burst_length`.
- **Beat counting:** each cycle with `mem_readdataid == i+1`, `beats[i]` decrements. `pending[i]` clears on the edge where the last beat arrives.
- **Stray beats:** a beat for a master whose `pending` is 0 is still flagged on `port_readdatavalid`. It does not underflow the counter, and the `STRAY_BEAT` sticky register bit records it.
- **Writes:** writes never set `pending`.
- **Return routing:** `port_readdatavalid[i] = (mem_readdataid == i+1)`, combinational, zero latency. `port_readdata = mem_readdata`.
- **Reset values:** `A_IDLE`, `grant=0`, `pending=0`, `beats=0`, `mem_read=0`, `mem_write=0`, `mem_id=0`, `mem_address=0`, `mem_writedata=0`, `mem_writedatamask=0`, round-robin pointer = master 0.

## Timing
- Minimum command latency: request seen in cycle 0 → `mem_read`/`mem_write` high in cycle 1 → accepted in cycle 1 if the downstream is idle. Master sees `port_waitrequest=0` in cycle 1.
- One `A_IDLE` bubble between consecutive grants. Peak command rate: one per 2 cycles.
- Last beat and a new request from the same master in the same cycle: the master is ineligible that cycle and is granted no earlier than the next cycle.
- Reset asserted mid-grant or mid-burst: all state clears asynchronously and the downstream command drops immediately. Beats still arriving after reset release are flagged on `port_readdatavalid` and recorded in `STRAY_BEAT`.
- `beats` counters are `burst_bits+1` bits wide; they never wrap below 0.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin priority. After granting master k, the search order starts at master (k+1) mod 3. The pointer updates only on acceptance.
- Undefined: fixed priority, master 0 > master 1 > master 2. No pointer register.

## Structure
- Shared package `mem_arb_pkg`: state encodings `A_IDLE`/`A_GRANT`, `MEM_ARB_PORTS = 3`, id width 2, address width 30, data width 32.
- One sub-module, `mem_arb_pick`: given eligible mask and pointer, returns the one-hot winner. Combinational, with the round-robin/fixed choice inside.

## Test plan
- **Single read:** master 0 reads 0x100 with an idle downstream → `mem_read=1`, `mem_id=1` in cycle 1. Four beats with id 1 → `port_readdatavalid[0]` high 4 cycles, then `pending[0]` clears.
- **Contention, round-robin:** all three masters request each cycle with `MEM_ARB_ROUND_ROBIN_EN` → grant order 0,1,2,0,1,2.
- **Contention, fixed:** same stimulus without the macro → master 0 is served whenever it is eligible.
- **Pending block:** master 1 issues a second read before its burst finishes → no grant to master 1 until the cycle after its 4th beat. Masters 0 and 2 are unaffected.
- **Downstream stall:** hold `mem_waitrequest=1` for 5 cycles during a write of 0xDEADBEEF, mask 0x3 → `mem_*` stable throughout; `port_waitrequest[2]` drops only in the release cycle.
- **Reset mid-burst:** pull `rst_n` low after beat 2 → all outputs reach their reset values with no clock edge. After release, `pending=0`, `beats=0`, and a new request is granted normally.
